// File: rtl/fir_fold_pkg.sv
// Shared constants and types for the folded FIR: widths, saturation limits
// and the sequencer state encoding.
package fir_fold_pkg;

  localparam int NT   = 11;
  localparam int WD   = 11;
  localparam int FRAC = 10;
  localparam int PW   = 22;
  localparam int AW   = 26;

  // Largest and smallest accumulator values that still fit the output after the Q1.10 shift
  localparam logic signed [AW-1:0] SAT_HI  = 26'sd1048575;
  localparam logic signed [AW-1:0] SAT_LO  = -26'sd1048576;
  localparam logic signed [WD-1:0] OUT_MAX = 11'sh3FF;
  localparam logic signed [WD-1:0] OUT_MIN = 11'sh400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_fold_mac.sv
// Single multiply-accumulate unit shared by every tap of the folded filter.
// CLR wins over EN so a new sample always starts from an empty accumulator.
module fir_mac
  import fir_fold_pkg::*;
#(
  parameter int MWD = fir_fold_pkg::WD,
  parameter int MPW = fir_fold_pkg::PW,
  parameter int MAW = fir_fold_pkg::AW
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  EN,
  input  logic signed [MWD-1:0] A,
  input  logic signed [MWD-1:0] B,
  output logic signed [MAW-1:0] ACC
);

  logic signed [MPW-1:0] product;
  logic signed [MAW-1:0] acc_q, acc_d;

  assign product = A * B;

  always_comb begin
    acc_d = acc_q;
    if (CLR) begin
      acc_d = '0;
    end else if (EN) begin
      acc_d = acc_q + MAW'(product);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign ACC = acc_q;

endmodule

// File: rtl/fir_fold_ctrl.sv
// Folded FIR: one sample in, NT multiply-accumulate cycles, one saturated
// result out. Holds the sample ring, coefficient file, tap counter and FSM.
module fir_fold_ctrl #(
  parameter int NT = fir_fold_pkg::NT,
  parameter int WD = fir_fold_pkg::WD
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [WD-1:0] DIN,
  input  logic          VIN,
  output logic          RDY,
  input  logic          CWE,
  input  logic [3:0]    CADDR,
  input  logic [WD-1:0] CDATA,
  output logic [WD-1:0] DOUT,
  output logic          VOUT
);

  import fir_fold_pkg::*;

  localparam int IW = $clog2(NT);
  localparam logic [IW-1:0] LastTap = IW'(NT - 1);
  localparam logic [IW-1:0] NtIdx   = IW'(NT);

  state_t state_q, state_d;

  logic [IW-1:0] tapCnt_q, tapCnt_d;
  logic [IW-1:0] wrPtr_q, wrPtr_d;
  logic [IW-1:0] curPtr_q, curPtr_d;
  logic [IW-1:0] rdIdx;
  logic [WD-1:0] dout_q, dout_d;
  logic          vout_q, vout_d;
  logic [WD-1:0] satOut;
  logic [WD-1:0] sampleBuf_q [NT];
  logic [WD-1:0] coefFile_q [NT];

  logic                 accept;
  logic                 coefWrite;
  logic                 macClr;
  logic                 macEn;
  logic signed [AW-1:0] acc;

  assign RDY       = (state_q == IDLE) && !RST;
  assign accept    = VIN && RDY;
  assign coefWrite = CWE && RDY && (int'(CADDR) < NT);

  // Tap k reads the sample k positions older than the one just written, wrapping the ring
  assign rdIdx = (curPtr_q >= tapCnt_q) ? (curPtr_q - tapCnt_q)
                                        : (curPtr_q + NtIdx - tapCnt_q);

  fir_mac #(
    .MWD(WD),
    .MPW(PW),
    .MAW(AW)
  ) u_mac (
    .CLK(CLK),
    .RST(RST),
    .CLR(macClr),
    .EN (macEn),
    .A  (coefFile_q[tapCnt_q]),
    .B  (sampleBuf_q[rdIdx]),
    .ACC(acc)
  );

  always_comb begin
    if (acc > SAT_HI) begin
      satOut = OUT_MAX;
    end else if (acc < SAT_LO) begin
      satOut = OUT_MIN;
    end else begin
      satOut = acc[FRAC+WD-1:FRAC];
    end
  end

  always_comb begin
    state_d  = state_q;
    tapCnt_d = tapCnt_q;
    wrPtr_d  = wrPtr_q;
    curPtr_d = curPtr_q;
    dout_d   = dout_q;
    vout_d   = 1'b0;
    macClr   = 1'b0;
    macEn    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          curPtr_d = wrPtr_q;
          wrPtr_d  = (wrPtr_q == LastTap) ? '0 : wrPtr_q + 1'b1;
          tapCnt_d = '0;
          macClr   = 1'b1;
          state_d  = MAC;
        end
      end
      MAC: begin
        macEn = 1'b1;
        if (tapCnt_q == LastTap) begin
          state_d = DONE;
        end else begin
          tapCnt_d = tapCnt_q + 1'b1;
        end
      end
      DONE: begin
        dout_d  = satOut;
        vout_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tapCnt_q <= '0;
      wrPtr_q  <= '0;
      curPtr_q <= '0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tapCnt_q <= tapCnt_d;
      wrPtr_q  <= wrPtr_d;
      curPtr_q <= curPtr_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
    end
  end

  // A coefficient written on the accept edge is already in place for the first MAC cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NT; i++) begin
        sampleBuf_q[i] <= '0;
        coefFile_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        sampleBuf_q[wrPtr_q] <= DIN;
      end
      if (coefWrite) begin
        coefFile_q[CADDR[IW-1:0]] <= CDATA;
      end
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Directed self-checking bench for fir_fold_ctrl: impulse, saturation,
// back-to-back, reset abort and ignored coefficient writes.
module tb_fir_fold_ctrl;

  logic               clk;
  logic               rst;
  logic signed [10:0] din;
  logic               vin;
  logic               rdy;
  logic               cwe;
  logic [3:0]         caddr;
  logic signed [10:0] cdata;
  logic signed [10:0] dout;
  logic               vout;

  int checks;
  int errors;

  fir_fold_ctrl #(
    .NT(11),
    .WD(11)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .DIN  (din),
    .VIN  (vin),
    .RDY  (rdy),
    .CWE  (cwe),
    .CADDR(caddr),
    .CDATA(cdata),
    .DOUT (dout),
    .VOUT (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    vin = 1'b0;
    cwe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic writeCoef(input logic [3:0] a, input logic signed [10:0] v);
    @(negedge clk);
    cwe   = 1'b1;
    caddr = a;
    cdata = v;
    @(negedge clk);
    cwe = 1'b0;
  endtask

  // lat is the number of rising edges from the accept edge to the VOUT edge, or 0 when VOUT never rises
  task automatic sendSample(input logic signed [10:0] x, input bit cweNow, input bit cweMid,
                            input logic [3:0] ca, input logic signed [10:0] cd,
                            output logic signed [10:0] res, output int lat);
    int waitCnt;
    waitCnt = 0;
    lat     = 0;
    res     = '0;
    @(negedge clk);
    while (!rdy && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    din   = x;
    vin   = 1'b1;
    cwe   = cweNow;
    caddr = ca;
    cdata = cd;
    @(negedge clk);
    vin = 1'b0;
    cwe = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (cweMid && n == 3) begin
        cwe   = 1'b1;
        caddr = ca;
        cdata = cd;
      end
      if (n == 4) begin
        cwe = 1'b0;
      end
      if (vout) begin
        lat = n;
        res = dout;
        break;
      end
    end
    cwe = 1'b0;
  endtask

  task automatic test_basic();
    logic signed [10:0] r;
    int                 l;
    resetDut();
    writeCoef(4'd0, 11'sd512);
    sendSample(11'sd200, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
    checks++;
    if (r !== 11'sd100) begin
      errors++;
      $display("[TB] FAIL basic_dout got %0d expected 100", r);
    end
    checks++;
    if (l !== 12) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d expected 12", l);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (vout !== 1'b0 || dout !== 11'sd100) begin
      errors++;
      $display("[TB] FAIL basic_hold got vout=%0b dout=%0d expected vout=0 dout=100", vout, dout);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    vin = 1'b1;
    din = 11'sd77;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rdy_low got %0b expected 0", rdy);
    end
    checks++;
    if (dout !== 11'sd0 || vout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got dout=%0d vout=%0b expected 0 0", dout, vout);
    end
    rst = 1'b0;
    vin = 1'b0;
    #1;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_rdy_first got %0b expected 1", rdy);
    end
  endtask

  task automatic test_impulse();
    logic signed [10:0] r;
    logic signed [10:0] exp;
    int                 l;
    resetDut();
    for (int k = 0; k < 11; k++) begin
      writeCoef(4'(k), 11'(16 * (k + 1)));
    end
    for (int n = 0; n < 12; n++) begin
      sendSample((n == 0) ? 11'sd1023 : 11'sd0, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
      exp = (n < 11) ? 11'(16 * (n + 1) - 1) : 11'sd0;
      checks++;
      if (r !== exp || l !== 12) begin
        errors++;
        $display("[TB] FAIL impulse_%0d got dout=%0d lat=%0d expected dout=%0d lat=12", n, r, l, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [10:0] r;
    logic signed [10:0] first;
    logic signed [10:0] negMin;
    int                 l;
    negMin = 11'h400;
    for (int pass = 0; pass < 2; pass++) begin
      resetDut();
      for (int k = 0; k < 11; k++) begin
        writeCoef(4'(k), 11'sd1023);
      end
      first = '0;
      for (int n = 0; n < 11; n++) begin
        sendSample((pass == 0) ? 11'sd1023 : negMin, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
        if (n == 0) begin
          first = r;
        end
      end
      checks++;
      if (first !== ((pass == 0) ? 11'sd1022 : -11'sd1023)) begin
        errors++;
        $display("[TB] FAIL sat_first_%0d got %0d expected %0d", pass, first,
                 (pass == 0) ? 1022 : -1023);
      end
      checks++;
      if (r !== ((pass == 0) ? 11'sd1023 : negMin)) begin
        errors++;
        $display("[TB] FAIL sat_final_%0d got %0d expected %0d", pass, r,
                 (pass == 0) ? 1023 : -1024);
      end
    end
  endtask

  task automatic test_back_to_back();
    int                 accepts;
    int                 vouts;
    int                 lastAcc;
    logic               r;
    logic signed [10:0] exp;
    resetDut();
    writeCoef(4'd0, 11'sd512);
    accepts = 0;
    vouts   = 0;
    lastAcc = -100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vin = 1'b1;
      din = 11'(4 * c + 2);
      r   = rdy;
      @(posedge clk);
      if (r) begin
        if (accepts > 0) begin
          checks++;
          if (c - lastAcc !== 13) begin
            errors++;
            $display("[TB] FAIL b2b_interval got %0d expected 13", c - lastAcc);
          end
        end
        accepts++;
        lastAcc = c;
      end
      #1;
      if (vout) begin
        vouts++;
        exp = 11'(2 * lastAcc + 1);
        checks++;
        if (dout !== exp || c - lastAcc !== 12) begin
          errors++;
          $display("[TB] FAIL b2b_result got dout=%0d lat=%0d expected dout=%0d lat=12",
                   dout, c - lastAcc, exp);
        end
      end
    end
    @(negedge clk);
    vin = 1'b0;
    checks++;
    if (accepts !== 4) begin
      errors++;
      $display("[TB] FAIL b2b_accepts got %0d expected 4", accepts);
    end
    checks++;
    if (vouts !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_vouts got %0d expected 3", vouts);
    end
  endtask

  task automatic test_reset_abort();
    logic signed [10:0] r;
    int                 l;
    int                 vouts;
    resetDut();
    for (int k = 0; k < 11; k++) begin
      writeCoef(4'(k), 11'sd512);
    end
    for (int n = 1; n <= 3; n++) begin
      sendSample(11'sd300, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
      checks++;
      if (r !== 11'(150 * n)) begin
        errors++;
        $display("[TB] FAIL abort_pre_%0d got %0d expected %0d", n, r, 150 * n);
      end
    end
    @(negedge clk);
    din = 11'sd400;
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    vouts = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (vout) begin
        vouts++;
      end
    end
    checks++;
    if (vouts !== 0 || dout !== 11'sd0) begin
      errors++;
      $display("[TB] FAIL abort_no_vout got vouts=%0d dout=%0d expected 0 0", vouts, dout);
    end
    writeCoef(4'd0, 11'sd512);
    sendSample(11'sd200, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
    checks++;
    if (r !== 11'sd100) begin
      errors++;
      $display("[TB] FAIL abort_after got %0d expected 100", r);
    end
    sendSample(11'sd0, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
    checks++;
    if (r !== 11'sd0) begin
      errors++;
      $display("[TB] FAIL abort_coef_cleared got %0d expected 0", r);
    end
    for (int k = 1; k < 11; k++) begin
      writeCoef(4'(k), 11'sd512);
    end
    sendSample(11'sd0, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
    checks++;
    if (r !== 11'sd100) begin
      errors++;
      $display("[TB] FAIL abort_history_cleared got %0d expected 100", r);
    end
  endtask

  task automatic test_coef_ignore();
    logic signed [10:0] r;
    int                 l;
    resetDut();
    writeCoef(4'd0, 11'sd512);
    sendSample(11'sd200, 1'b1, 1'b0, 4'd0, 11'sd256, r, l);
    checks++;
    if (r !== 11'sd50) begin
      errors++;
      $display("[TB] FAIL coef_same_edge got %0d expected 50", r);
    end
    sendSample(11'sd100, 1'b0, 1'b1, 4'd1, 11'sd512, r, l);
    checks++;
    if (r !== 11'sd25) begin
      errors++;
      $display("[TB] FAIL coef_mid_mac_result got %0d expected 25", r);
    end
    writeCoef(4'd11, 11'sd512);
    writeCoef(4'd15, 11'sd512);
    sendSample(11'sd0, 1'b0, 1'b0, 4'd0, 11'sd0, r, l);
    checks++;
    if (r !== 11'sd0 || l !== 12) begin
      errors++;
      $display("[TB] FAIL coef_unchanged got dout=%0d lat=%0d expected dout=0 lat=12", r, l);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    vin    = 1'b0;
    din    = '0;
    cwe    = 1'b0;
    caddr  = '0;
    cdata  = '0;
    resetDut();
    test_basic();
    test_reset();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_coef_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_fold_ctrl.md
FIR_FOLD_CTRL -- requirements
Module: fir_fold_ctrl

Interface
REQ-001 Parameter NT, default 11, SHALL set the number of taps.
REQ-002 Parameter WD, default 11, SHALL set the sample, coefficient and output width.
REQ-003 CLK  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 DIN  in  WD  SHALL carry the input sample, two's complement.
REQ-006 VIN  in  1  SHALL mark DIN valid.
REQ-007 RDY  out  1  SHALL be high when a sample or coefficient write can be accepted.
REQ-008 CWE  in  1  SHALL request a coefficient write.
REQ-009 CADDR  in  4  SHALL give the coefficient index.
REQ-010 CDATA  in  WD  SHALL carry the coefficient value, two's complement Q1.10.
REQ-011 DOUT  out  WD  SHALL carry the filtered sample, two's complement.
REQ-012 VOUT  out  1  SHALL mark DOUT valid for exactly one cycle per result.

Function
REQ-013 The block SHALL be a folded FIR with one multiplier-accumulator, sequenced by FSM states IDLE, MAC and DONE.
REQ-014 RDY SHALL equal (state==IDLE) and SHALL be 0 while RST is high.
REQ-015 A sample SHALL be accepted at an edge E where VIN=1 and RDY=1; DIN is then written to sample-buffer slot p=wptr, wptr advances with wrap 10->0, acc clears and the tap counter k is set to 0 (IDLE->MAC).
REQ-016 VIN at an edge with RDY=0 SHALL be ignored; the sample is dropped and no state changes.
REQ-017 In MAC, at edges E+1..E+11 the block SHALL do acc += C[k]*x[(p-k) mod NT] with k=0..10, and SHALL go MAC->DONE at E+11.
REQ-018 At edge E+12 in DONE, DOUT SHALL load sat(acc[20:10]), VOUT SHALL go to 1 for one cycle, and the FSM SHALL return to IDLE; the next sample can be accepted at E+13.
REQ-019 Products SHALL be 22-bit signed; acc SHALL be 26-bit signed; no overflow is possible inside acc.
REQ-020 The output stage SHALL saturate: acc > 1023*1024+1023 -> DOUT=+1023; acc < -1024*1024 -> DOUT=-1024; otherwise DOUT=acc[20:10] (floor, arithmetic shift).
REQ-021 CWE=1 with RDY=1 and CADDR<=10 SHALL write CDATA to C[CADDR]; CADDR>10 or RDY=0 SHALL cause the write to be ignored.
REQ-022 When CWE and VIN are accepted at the same edge, the new coefficient SHALL be used for that sample.
REQ-023 DOUT SHALL hold its value between results.

Reset
REQ-024 RST high at an edge SHALL set state=IDLE, wptr=0, k=0, acc=0, DOUT=0, VOUT=0, all NT sample slots=0 and all coefficients=0.
REQ-025 RST asserted during MAC or DONE SHALL abort the computation; no VOUT is produced for the aborted sample.
REQ-026 After RST deasserts, RDY SHALL be 1 in the first cycle.

Structure
REQ-027 Package fir_fold_pkg SHALL hold NT, WD, the product width (22), the accumulator width (26), the saturation limits and the state enum typedef.
REQ-028 The multiply-accumulate SHALL be a sub-module fir_mac with ports CLK, RST, CLR, EN, A, B, ACC; the sample buffer, coefficient file, tap counter and FSM SHALL stay in fir_fold_ctrl.

Verification
REQ-029 After reset, write C0=512 (others 0) and send DIN=200 -> DOUT=100, with VOUT high exactly 12 edges after the accept edge.
REQ-030 Impulse: set C[k]=16*(k+1), send DIN=1023 then 10 samples of 0 -> outputs 15,31,47,...,175 (16(k+1)-1); a 12th sample of 0 -> DOUT=0.
REQ-031 Saturation: all C=1023 and 11 samples of 1023 -> final DOUT=+1023; all C=1023 and 11 samples of -1024 -> final DOUT=-1024.
REQ-032 Hold VIN=1 continuously -> accepts occur every 13 cycles, one VOUT per accepted sample, and RDY is low during MAC/DONE.
REQ-033 Assert RST 5 cycles after an accept -> no VOUT and DOUT=0; a following DIN=200 with C0=512 rewritten -> DOUT=100 and the other taps contribute zero history.
REQ-034 CWE issued during MAC, and CWE with CADDR=11 in IDLE -> the coefficient file is unchanged; the next result matches the prior coefficients.
